// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the R3 multi-cycle control unit.
// State HALT exists only when MC_CTRL_ILLEGAL_HALT_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    LUI      = 4'd8,
    ALUWB    = 4'd9,
    BRANCH   = 4'd10
`ifdef MC_CTRL_ILLEGAL_HALT_EN
    , HALT   = 4'd11
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_U = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// ALU operation decode from op/funct3/funct7b5 for R-type and I-type ALU ops.
module alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      // Only register-register ops encode sub; addi with instr[30] set stays add.
      3'b000:  alu_control = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control = ALU_SLT;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the R3 RV32I core (lw, sw, R/I ALU, beq/bne, lui).
// Define MC_CTRL_ILLEGAL_HALT_EN to trap unknown opcodes in HALT with a Halted output.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       Retire
`ifdef MC_CTRL_ILLEGAL_HALT_EN
  , output logic     Halted
`endif
);

  state_t     state;
  logic [2:0] alu_op;
  logic       pc_write_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       retire_raw;

  alu_dec u_alu_dec (
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_STATE;
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= MEMADR;
            OP_RTYPE:          state <= EXECR;
            OP_ITYPE:          state <= EXECI;
            OP_BRANCH:         state <= BRANCH;
            OP_LUI:            state <= LUI;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
            default:           state <= HALT;
`else
            default:           state <= FETCH;
`endif
          endcase
        end
        MEMADR:   state <= (op == OP_STORE) ? MEMWRITE : MEMREAD;
        MEMREAD:  state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        LUI:      state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
        HALT:     state <= HALT;
`endif
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    AdrSrc        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    ImmSrc        = IMM_I;
    ALUControl    = ALU_ADD;
    reg_write_raw = 1'b0;
    retire_raw    = 1'b0;
    case (state)
      FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
`ifndef MC_CTRL_ILLEGAL_HALT_EN
        retire_raw = !(op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_LUI});
`endif
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc     = RES_MEMDATA;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = alu_op;
      end
      EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_I;
        ALUControl = alu_op;
      end
      LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      BRANCH: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_RS2;
        ALUControl   = ALU_SUB;
        pc_write_raw = Zero ^ funct3[0];
        retire_raw   = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by rst itself so an abandoned instruction cannot write after rst rises.
  assign PCWrite  = pc_write_raw  & ~rst;
  assign MemWrite = mem_write_raw & ~rst;
  assign IRWrite  = ir_write_raw  & ~rst;
  assign RegWrite = reg_write_raw & ~rst;
  assign Retire   = retire_raw    & ~rst;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
  assign Halted   = (state == HALT);
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm; exercises each instruction class and reset behaviour.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
  logic       Halted;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite),
    .Retire     (Retire)
`ifdef MC_CTRL_ILLEGAL_HALT_EN
    , .Halted   (Halted)
`endif
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
  endtask

  // R-type funct3 sweep: expected ALUControl in EXECR
  logic [2:0] r_f3  [5] = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b100};
  logic       r_f7  [5] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
  logic [2:0] r_exp [5] = '{3'b000, 3'b101, 3'b011, 3'b010, 3'b000};

  initial begin
    rst = 1'b1;
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_pcwrite", PCWrite, 0);
    check("rst_irwrite", IRWrite, 0);
    check("rst_retire",  Retire, 0);
    check("rst_srcb",    ALUSrcB, 2'b10);
    check("rst_res",     ResultSrc, 2'b10);
    rst = 1'b0;
    #1;
    check("fetch_irwrite", IRWrite, 1);
    check("fetch_pcwrite", PCWrite, 1);

    // lw: 5 cycles
    step(); check("lw_dec_srca", ALUSrcA, 2'b01); check("lw_dec_imm", ImmSrc, 2'b10);
    check("lw_dec_retire", Retire, 0);
    step(); check("lw_madr_imm", ImmSrc, 2'b00); check("lw_madr_srca", ALUSrcA, 2'b10);
    step(); check("lw_mrd_adr", AdrSrc, 1); check("lw_mrd_regw", RegWrite, 0);
    step(); check("lw_wb_res", ResultSrc, 2'b01); check("lw_wb_regw", RegWrite, 1);
    check("lw_wb_retire", Retire, 1);
    step(); check("lw_next_fetch", IRWrite, 1);

    // sw: 4 cycles, single MemWrite pulse
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    check("sw_fetch_memw", MemWrite, 0);
    step(); check("sw_dec_regw", RegWrite, 0);
    step(); check("sw_madr_imm", ImmSrc, 2'b01); check("sw_madr_memw", MemWrite, 0);
    step(); check("sw_mwr_memw", MemWrite, 1); check("sw_mwr_adr", AdrSrc, 1);
    check("sw_mwr_regw", RegWrite, 0); check("sw_mwr_retire", Retire, 1);
    step(); check("sw_next_memw", MemWrite, 0); check("sw_next_fetch", IRWrite, 1);

    // R-type sub
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    step(); step();
    check("sub_alu", ALUControl, 3'b001); check("sub_srcb", ALUSrcB, 2'b00);
    step(); check("sub_wb_regw", RegWrite, 1); check("sub_wb_retire", Retire, 1);
    step(); check("sub_next_fetch", IRWrite, 1);

    // R-type funct3 sweep
    for (int i = 0; i < 5; i++) begin
      set_instr(7'b0110011, r_f3[i], r_f7[i], 1'b0);
      step(); step();
      check($sformatf("r_alu_%0d", i), ALUControl, r_exp[i]);
      step(); step();
    end

    // addi with funct7b5=1 stays add
    set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
    step(); step();
    check("addi_alu", ALUControl, 3'b000); check("addi_imm", ImmSrc, 2'b00);
    check("addi_srcb", ALUSrcB, 2'b01);
    step(); check("addi_wb_regw", RegWrite, 1);
    step();

    // slti
    set_instr(7'b0010011, 3'b010, 1'b0, 1'b0);
    step(); step(); check("slti_alu", ALUControl, 3'b101);
    step(); step();

    // bne, Zero=1: no PC update, 3 cycles
    set_instr(7'b1100011, 3'b001, 1'b0, 1'b1);
    step(); step();
    check("bne_z1_pcw", PCWrite, 0); check("bne_alu", ALUControl, 3'b001);
    check("bne_retire", Retire, 1);
    step(); check("bne_next_fetch", IRWrite, 1);

    // beq, Zero=1: taken
    set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
    step(); step();
    check("beq_z1_pcw", PCWrite, 1); check("beq_retire", Retire, 1);
    step(); check("beq_next_fetch", IRWrite, 1);

    // bne, Zero=0: taken
    set_instr(7'b1100011, 3'b001, 1'b0, 1'b0);
    step(); step(); check("bne_z0_pcw", PCWrite, 1);
    step();

    // lui
    set_instr(7'b0110111, 3'b000, 1'b0, 1'b0);
    step(); step();
    check("lui_imm", ImmSrc, 2'b11); check("lui_srca", ALUSrcA, 2'b11);
    check("lui_regw", RegWrite, 0);
    step(); check("lui_wb_regw", RegWrite, 1); check("lui_wb_retire", Retire, 1);
    step(); check("lui_next_fetch", IRWrite, 1);

    // unknown opcode
    set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
    step();
`ifdef MC_CTRL_ILLEGAL_HALT_EN
    check("ill_dec_retire", Retire, 0);
    step(); check("ill_halted", Halted, 1); check("ill_irw", IRWrite, 0);
    check("ill_pcw", PCWrite, 0);
    step(); check("ill_still_halted", Halted, 1); check("ill_retire", Retire, 0);
    rst = 1'b1; #2; rst = 1'b0; #1;
    check("ill_rst_halted", Halted, 0); check("ill_rst_fetch", IRWrite, 1);
`else
    check("ill_dec_retire", Retire, 1);
    step(); check("ill_next_fetch", IRWrite, 1);
`endif

    // reset in the middle of MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    step(); step(); step();
    check("mid_memw_before", MemWrite, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_memw_dropped", MemWrite, 0);
    check("mid_retire", Retire, 0);
    check("mid_regw", RegWrite, 0);
    step();
    check("mid_hold_memw", MemWrite, 0);
    rst = 1'b0;
    #1;
    check("mid_rel_irw", IRWrite, 1); check("mid_rel_pcw", PCWrite, 1);
    step(); check("mid_rel_decode", ALUSrcA, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control unit for the R3 RV32I core. The core shares one ALU, one memory port and the immediate extender across cycles.
- Sequences fetch/decode/execute/writeback per instruction.
- Drives ImmSrc (I=00, S=01, B=10, U=11), ALU operand muxes, memory/register write enables and PC update.
- Supports lw, sw, R-type ALU, I-type ALU, beq, bne, lui.

Parameters:
- RESET_STATE, FETCH, state entered on reset.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- Zero  in  1  ALU zero flag, same cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0=PC, 1=ALUOut to memory address
- MemWrite  out  1  data memory write
- IRWrite  out  1  instruction/OldPC register enable
- ResultSrc  out  2  00=ALUOut, 01=MemData, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero
- ALUSrcB  out  2  00=rs2, 01=ImmExt, 10=const 4
- ImmSrc  out  2  to immediate extender
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  out  1  register file write
- Retire  out  1  one-cycle pulse in final state of each instruction

Behaviour:
- Moore FSM; all outputs are combinational from the state register, plus op/funct for ALUControl/ImmSrc and Zero for PCWrite. State updates on the rising edge of clk.
- rst asserted asynchronously forces state=FETCH. While rst is high, PCWrite, MemWrite, IRWrite, RegWrite and Retire are forced 0. Other outputs hold their FETCH values.
- Unlisted outputs are 0 in each state.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1 -> DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add (precomputes branch target into ALUOut).
  - op 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 0110111 -> LUI
  - other -> FETCH (treated as nop, Retire=1 in DECODE)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=00 (lw) / 01 (sw), add. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, Retire=1 -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU decode -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALU decode -> ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ImmSrc=11, add -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1 -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite = Zero XOR funct3[0] (beq 000, bne 001), Retire=1 -> FETCH.
- ALU decode by funct3:
  - 000: sub if op=0110011 and funct7b5=1, else add
  - 010: slt
  - 110: or
  - 111: and
  - others: add
- Latencies:
  - lw 5 cycles
  - sw, R, I, lui 4 cycles
  - branch 3 cycles
  - unknown opcode 2 cycles
- Reset mid-instruction abandons it; no partial write occurs after rst rises.

Optional Feature:
- Macro MC_CTRL_ILLEGAL_HALT_EN.
- Defined:
  - Unknown opcode in DECODE -> HALT state.
  - HALT: all enables 0, Retire=0, plus an extra output Halted=1.
  - HALT is left only by rst.
- Undefined:
  - No HALT state and no Halted port.
  - Unknown opcode returns to FETCH as a nop.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum type
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_LUI)
  - ImmSrc codes (IMM_I/S/B/U)
  - ALUControl codes
  - mux-select codes
- Sub-module alu_dec (combinational op/funct3/funct7b5 -> ALUControl), instantiated once.

Test Plan:
- Reset: rst=1 mid-MEMWRITE -> MemWrite drops to 0 immediately. After release, state FETCH with IRWrite=1 and PCWrite=1.
- lw (op 0000011): FETCH, DECODE, MEMADR (ImmSrc=00), MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1, Retire=1). Total 5 cycles.
- sw (op 0100011): MEMADR drives ImmSrc=01. MEMWRITE asserts MemWrite=1 for exactly 1 cycle. RegWrite=0 throughout.
- R-type sub (funct3 000, funct7b5=1) -> ALUControl=001 in EXECR. addi with funct7b5=1 -> ALUControl=000.
- bne (funct3 001) with Zero=1 -> PCWrite=0 in BRANCH. beq with Zero=1 -> PCWrite=1. Both retire after 3 cycles.
- lui (op 0110111): ImmSrc=11 and ALUSrcA=11 in LUI, then RegWrite in ALUWB. Op 1111111 -> back to FETCH after 2 cycles, or HALT with Halted=1 when MC_CTRL_ILLEGAL_HALT_EN is defined.
